stream_compare_stats: RTL and testbench
=======================================

// Module: stream_compare_stats
// PURPOSE
// - Pipelined, width-parametrised magnitude comparator for a valid/ready stream of operand pairs (A,B).
// - Each beat selects signed or unsigned compare and produces a registered one-hot GT/EQ/LT result.
// - Accumulates GT/EQ/LT tallies over fixed windows of WIN accepted beats and reports them per window.
// - Successor to the 4-bit combinational compare unit; sits between the operand source and status/logging logic.
// PARAMETERS
// - WIDTH  default 8  operand width in bits; minimum 2
// - WIN    default 16 number of accepted beats per statistics window; minimum 1
// - CW     default $clog2(WIN+1)  tally counter width; derived, not overridden
// PORTS
// - clk          in   1      clock; rising edge
// - rst_n        in   1      reset; asynchronous assert, active-low
// - clear        in   1      synchronous flush of pipeline and window
// - in_valid     in   1      operand pair valid
// - in_ready     out  1      block can accept a pair this cycle
// - a, b         in   WIDTH  operands
// - signed_mode  in   1      1 = two's-complement compare, 0 = unsigned; sampled with the beat
// - out_valid    out  1      result valid
// - out_ready    in   1      downstream accepts result
// - out_res      out  3      one-hot {GT,EQ,LT}: 100 = A>B, 010 = A==B, 001 = A<B
// - win_valid    out  1      one-cycle pulse: window complete, tallies valid
// - gt_cnt, eq_cnt, lt_cnt  out  CW  tallies for the last completed window
// BEHAVIOUR
// - Reset: out_valid=0, out_res=000, win_valid=0, all tallies and internal counters 0, FSM=IDLE.
// - Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (one-entry skid-free stage).
// - Latency 1: result of an accepted beat appears on out_res/out_valid the next cycle.
// - out_res/out_valid hold stable while out_valid && !out_ready; out_res is always exactly one-hot when out_valid=1.
// - Signed compare: A[W-1]!=B[W-1] decides by sign bit alone; equal signs compare remaining bits unsigned.
// - Unsigned compare: plain magnitude; no subtraction-overflow artefacts permitted.
// - Tallies increment on the accepted beat (not on output handshake); window progress is independent of out_ready.
// - FSM: IDLE -(accept)-> ACCUM; ACCUM -(accept making beat count==WIN)-> DONE; DONE -> ACCUM if a beat is accepted that cycle, else IDLE.
// - In DONE cycle win_valid=1; gt/eq/lt_cnt updated to the completed window totals (sum == WIN); they hold until the next DONE.
// - Beat accepted during the DONE cycle is beat 1 of the new window. WIN=1: every accept produces DONE next cycle.
// - Internal beat counter and working tallies reset to 0 (or to the DONE-cycle beat) on window completion; no wrap.
// - clear: priority over accept; drops out_valid, zeroes working tallies and beat counter, FSM->IDLE; published tallies keep their values; win_valid=0 that cycle.
// - rst_n asserted mid-window: all state to reset values immediately, partial window discarded.
// STRUCTURE
// - Shared package cmp_pkg: localparams CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001; FSM state encoding (IDLE, ACCUM, DONE).
// - Sub-module cmp_core (combinational): inputs a, b, signed_mode; output one-hot res; instantiated once, reused by future compare blocks.
// - Top holds the result register, handshake logic, FSM and tally counters.
// TESTING
// - WIDTH=4, unsigned: a=4'b1000, b=4'b0111 -> out_res=100 one cycle after accept.
// - WIDTH=4, signed: same operands -> out_res=001; a=b=4'b1011 -> 010; a=4'b1111,b=4'b1110 -> 100.
// - Backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0, out_res stable, no beats lost; release -> next beat accepted.
// - WIN=4: beats GT,EQ,LT,GT back-to-back -> win_valid pulse with gt=2,eq=1,lt=1; 5th beat on DONE cycle counts in next window.
// - clear after 2 beats of a window -> out_valid=0, next 4 beats form a full window; prior published tallies unchanged until then.
// - rst_n low mid-window for 1 cycle -> all outputs 0 asynchronously; random signed/unsigned stream vs reference model afterwards.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared compare definitions: one-hot result codes and the window FSM encoding.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } win_state_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare of two WIDTH-bit operands, signed or unsigned,
// producing a one-hot {GT,EQ,LT} code.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic [2:0]       res
);

  always_comb begin
    res = CMP_EQ;
    // Differing sign bits settle a signed compare; otherwise the plain magnitude order is correct.
    if (signed_mode && (a[WIDTH-1] != b[WIDTH-1])) begin
      res = a[WIDTH-1] ? CMP_LT : CMP_GT;
    end else if (a > b) begin
      res = CMP_GT;
    end else if (a == b) begin
      res = CMP_EQ;
    end else begin
      res = CMP_LT;
    end
  end

endmodule

// File: rtl/stream_compare_stats.sv
// Valid/ready stream comparator with a one-deep result register and per-window
// GT/EQ/LT tallies published every WIN accepted beats.
module stream_compare_stats
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int WIN   = 16,
  localparam int CW    = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_res,
  output logic             win_valid,
  output logic [CW-1:0]    gt_cnt,
  output logic [CW-1:0]    eq_cnt,
  output logic [CW-1:0]    lt_cnt
);

  logic [2:0]    cmp_res;
  logic          accept;
  logic          win_done;
  logic [CW-1:0] beat_inc;

  logic          out_valid_q, out_valid_d;
  logic [2:0]    out_res_q,   out_res_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] wgt_q, wgt_d, weq_q, weq_d, wlt_q, wlt_d;
  logic [CW-1:0] pgt_q, pgt_d, peq_q, peq_d, plt_q, plt_d;
  win_state_e    state_q, state_d;

  cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .res         (cmp_res)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !clear;
  assign beat_inc = beat_q + CW'(1);
  assign win_done = accept && (beat_inc == CW'(WIN));

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign gt_cnt    = pgt_q;
  assign eq_cnt    = peq_q;
  assign lt_cnt    = plt_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    if (clear) begin
      out_valid_d = 1'b0;
      out_res_d   = 3'b000;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_res_d   = cmp_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_res_d   = 3'b000;
    end else begin
      out_valid_d = out_valid_q;
      out_res_d   = out_res_q;
    end
  end

  // Tallies follow accepted beats, not the output handshake; published set only moves on completion.
  always_comb begin
    beat_d = beat_q;
    wgt_d  = wgt_q;
    weq_d  = weq_q;
    wlt_d  = wlt_q;
    pgt_d  = pgt_q;
    peq_d  = peq_q;
    plt_d  = plt_q;
    if (clear) begin
      beat_d = '0;
      wgt_d  = '0;
      weq_d  = '0;
      wlt_d  = '0;
    end else if (win_done) begin
      beat_d = '0;
      wgt_d  = '0;
      weq_d  = '0;
      wlt_d  = '0;
      pgt_d  = wgt_q + CW'(cmp_res[2]);
      peq_d  = weq_q + CW'(cmp_res[1]);
      plt_d  = wlt_q + CW'(cmp_res[0]);
    end else if (accept) begin
      beat_d = beat_inc;
      wgt_d  = wgt_q + CW'(cmp_res[2]);
      weq_d  = weq_q + CW'(cmp_res[1]);
      wlt_d  = wlt_q + CW'(cmp_res[0]);
    end else begin
      beat_d = beat_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (win_done) begin
      state_d = DONE;
    end else if (accept) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   state_d = ACCUM;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    win_valid = 1'b0;
    case (state_q)
      DONE:    win_valid = !clear;
      default: win_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_res_q   <= 3'b000;
      beat_q      <= '0;
      wgt_q       <= '0;
      weq_q       <= '0;
      wlt_q       <= '0;
      pgt_q       <= '0;
      peq_q       <= '0;
      plt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      beat_q      <= beat_d;
      wgt_q       <= wgt_d;
      weq_q       <= weq_d;
      wlt_q       <= wlt_d;
      pgt_q       <= pgt_d;
      peq_q       <= peq_d;
      plt_q       <= plt_d;
    end
  end

endmodule

// File: tb/tb_stream_compare_stats.sv
// Self-checking bench for stream_compare_stats (WIDTH=4, WIN=4) against an
// integer-arithmetic reference model with a queue per statistics window.
module tb_stream_compare_stats;

  localparam int TW   = 4;
  localparam int TWIN = 4;
  localparam int TCW  = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear;
  logic           in_valid;
  logic           in_ready;
  logic [TW-1:0]  a;
  logic [TW-1:0]  b;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_res;
  logic           win_valid;
  logic [TCW-1:0] gt_cnt;
  logic [TCW-1:0] eq_cnt;
  logic [TCW-1:0] lt_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  bit         m_ov;
  logic [2:0] m_res;
  bit         m_win;
  int         m_gt, m_eq, m_lt;
  logic [2:0] m_q[$];

  always #5 clk = ~clk;

  stream_compare_stats #(.WIDTH(TW), .WIN(TWIN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .win_valid   (win_valid),
    .gt_cnt      (gt_cnt),
    .eq_cnt      (eq_cnt),
    .lt_cnt      (lt_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Operand values as integers; the larger integer wins.
  function automatic logic [2:0] ref_cmp(input logic [TW-1:0] x, input logic [TW-1:0] y, input bit sm);
    int ix = int'(x);
    int iy = int'(y);
    if (sm && x[TW-1]) ix = ix - (1 << TW);
    if (sm && y[TW-1]) iy = iy - (1 << TW);
    if (ix > iy) return 3'b100;
    else if (ix == iy) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_res = 3'b000; m_win = 0;
    m_gt = 0; m_eq = 0; m_lt = 0;
    m_q.delete();
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 8'(out_valid), 8'(m_ov));
    chk({tag, ".out_res"},   8'(out_res),   8'(m_res));
    chk({tag, ".win_valid"}, 8'(win_valid), 8'(m_win));
    chk({tag, ".gt_cnt"},    8'(gt_cnt),    8'(m_gt));
    chk({tag, ".eq_cnt"},    8'(eq_cnt),    8'(m_eq));
    chk({tag, ".lt_cnt"},    8'(lt_cnt),    8'(m_lt));
  endtask

  // Called #1 after a rising edge; drives one cycle of inputs and checks the result after the next edge.
  task automatic cycle(input string tag, input bit iv, input logic [TW-1:0] xa, input logic [TW-1:0] xb,
                       input bit sm, input bit ordy, input bit clr);
    bit acc;
    in_valid = iv; a = xa; b = xb; signed_mode = sm; out_ready = ordy; clear = clr;
    #1;
    chk({tag, ".in_ready"}, 8'(in_ready), 8'(!m_ov || ordy));
    acc = iv && (!m_ov || ordy) && !clr;
    @(posedge clk);
    #1;
    m_win = 0;
    if (clr) begin
      m_ov = 0; m_res = 3'b000;
      m_q.delete();
    end else if (acc) begin
      m_ov = 1; m_res = ref_cmp(xa, xb, sm);
      m_q.push_back(m_res);
      if (m_q.size() == TWIN) begin
        m_gt = 0; m_eq = 0; m_lt = 0;
        foreach (m_q[i]) begin
          if (m_q[i] == 3'b100) m_gt++;
          else if (m_q[i] == 3'b010) m_eq++;
          else m_lt++;
        end
        m_q.delete();
        m_win = 1;
      end
    end else if (ordy) begin
      m_ov = 0; m_res = 3'b000;
    end
    check_outs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] held;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; out_ready = 1'b1;
    model_reset();
    #1;
    check_outs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed window: GT, LT, EQ, GT back to back.
    cycle("u_1000_0111", 1, 4'b1000, 4'b0111, 0, 1, 0);
    chk("dir_unsigned_gt", 8'(out_res), 8'h04);
    cycle("s_1000_0111", 1, 4'b1000, 4'b0111, 1, 1, 0);
    chk("dir_signed_lt", 8'(out_res), 8'h01);
    cycle("s_1011_1011", 1, 4'b1011, 4'b1011, 1, 1, 0);
    chk("dir_signed_eq", 8'(out_res), 8'h02);
    cycle("s_1111_1110", 1, 4'b1111, 4'b1110, 1, 1, 0);
    chk("dir_signed_gt", 8'(out_res), 8'h04);
    chk("dir_win_pulse", 8'(win_valid), 8'h01);
    chk("dir_win_gt", 8'(gt_cnt), 8'h02);
    chk("dir_win_eq", 8'(eq_cnt), 8'h01);
    chk("dir_win_lt", 8'(lt_cnt), 8'h01);
    // Fifth beat lands on the DONE cycle and opens the next window.
    cycle("beat5_done", 1, 4'b0001, 4'b0010, 0, 1, 0);
    chk("dir_win_pulse_gone", 8'(win_valid), 8'h00);
    chk("dir_win_beat5_count", 8'(m_q.size()), 8'h01);

    // Backpressure: result held for three cycles, the waiting beat is taken on release.
    cycle("bp_first", 1, 4'b0011, 4'b0101, 0, 1, 0);
    held = out_res;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold", 1, 4'b1110, 4'b0010, 0, 0, 0);
      chk("bp_res_stable", 8'(out_res), 8'(held));
      chk("bp_in_ready_low", 8'(in_ready), 8'h00);
    end
    cycle("bp_release", 1, 4'b1110, 4'b0010, 0, 1, 0);
    chk("bp_released_beat", 8'(out_res), 8'h04);
    cycle("bp_drain", 0, 4'b0000, 4'b0000, 0, 1, 0);

    // Clear after two beats; the following four beats form a full window.
    cycle("clr_pre", 0, 4'b0000, 4'b0000, 0, 1, 1);
    cycle("clr_b1", 1, 4'b0111, 4'b0111, 0, 1, 0);
    cycle("clr_b2", 1, 4'b0001, 4'b1001, 1, 1, 0);
    cycle("clr_mid", 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk("clr_out_valid_low", 8'(out_valid), 8'h00);
    for (int i = 0; i < TWIN; i++) begin
      cycle("clr_win", 1, 4'(i), 4'(2), 1, 1, 0);
      if (i < TWIN - 1) chk("clr_no_early_win", 8'(win_valid), 8'h00);
    end
    chk("clr_full_window", 8'(win_valid), 8'h01);

    // Asynchronous reset in the middle of a window.
    cycle("rst_b1", 1, 4'b0100, 4'b0011, 0, 1, 0);
    cycle("rst_b2", 1, 4'b0100, 4'b0101, 0, 0, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random stream against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(3, 0) != 0), 4'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(3, 0) != 0), ($urandom_range(39, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
